score_sequencer: RTL

Controller that sequences the pitch-scoring datapath. It pops song and reference frequency samples from their two FIFOs in lockstep and presents each pair to the comparison unit with a start pulse. It waits for the comparison result and forwards each score to the tally averager as a one-cycle strobe. It sits between the FIFO pair and the comparison/tally blocks, replacing direct valid-to-start wiring with a guarded, timeout-protected handshake.

---
 rtl/score_sequencer_pkg.sv | 21 ++
 rtl/score_sequencer_sat_counter.sv | 20 ++
 rtl/score_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/score_sequencer_pkg.sv
// Shared definitions for the pitch-scoring sequencer: state encoding and default widths.
package score_sequencer_pkg;

    localparam int unsigned FREQ_W_DEF  = 15;
    localparam int unsigned SCORE_W_DEF = 4;
    localparam int unsigned CNT_W_DEF   = 16;
    localparam int unsigned TIMEOUT_DEF = 1023;

    // A frequency sample of 0 Hz marks silence; such pairs are dropped, not scored.
    localparam int unsigned SILENCE_HZ  = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_LATCH = 3'd2,
        ST_ISSUE = 3'd3,
        ST_WAIT  = 3'd4,
        ST_EMIT  = 3'd5
    } state_e;

endpackage : score_sequencer_pkg

// File: rtl/score_sequencer_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    // Count one per inc cycle until the counter is full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (inc && (q != {WIDTH{1'b1}})) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule : sat_counter

// File: rtl/score_sequencer.sv
// Sequences FIFO pairs through the comparison unit and forwards scores to the tally block.
module score_sequencer
    import score_sequencer_pkg::*;
#(
    parameter int unsigned FREQ_W  = FREQ_W_DEF,
    parameter int unsigned SCORE_W = SCORE_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               song_empty,
    input  logic               ref_empty,
    input  logic [FREQ_W-1:0]  song_dout,
    input  logic [FREQ_W-1:0]  ref_dout,
    output logic               song_rd_en,
    output logic               ref_rd_en,
    output logic               cmp_start,
    output logic [FREQ_W-1:0]  cmp_sung,
    output logic [FREQ_W-1:0]  cmp_ref,
    input  logic               cmp_score_ready,
    input  logic [SCORE_W-1:0] cmp_score,
    output logic               tally_valid,
    output logic [SCORE_W-1:0] tally_score,
    output logic [CNT_W-1:0]   scored_count,
    output logic [CNT_W-1:0]   skipped_count,
    output logic               timeout_err,
    output logic               busy
);

    localparam int unsigned TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_e              state_q;
    logic                rd_en_q;
    logic                cmp_start_q;
    logic                tally_valid_q;
    logic                timeout_q;
    logic                busy_q;
    logic [FREQ_W-1:0]   sung_q;
    logic [FREQ_W-1:0]   ref_q;
    logic [SCORE_W-1:0]  score_q;
    logic [TMR_W-1:0]    timer_q;

    logic                pair_silent;
    logic                skip_inc;
    logic                scored_inc;

    // Silence on either side drops the pair at LATCH.
    assign pair_silent = (song_dout == FREQ_W'(SILENCE_HZ)) || (ref_dout == FREQ_W'(SILENCE_HZ));
    assign skip_inc    = (state_q == ST_LATCH) && pair_silent;
    assign scored_inc  = (state_q == ST_EMIT);

    // Sequencer FSM with registered strobes, operands, score, timer and status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            rd_en_q       <= 1'b0;
            cmp_start_q   <= 1'b0;
            tally_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            busy_q        <= 1'b0;
            sung_q        <= '0;
            ref_q         <= '0;
            score_q       <= '0;
            timer_q       <= '0;
        end else begin
            rd_en_q       <= 1'b0;
            cmp_start_q   <= 1'b0;
            tally_valid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (run && !song_empty && !ref_empty) begin
                        state_q <= ST_POP;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_POP: begin
                    state_q <= ST_LATCH;
                end
                ST_LATCH: begin
                    sung_q <= song_dout;
                    ref_q  <= ref_dout;
                    if (pair_silent) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q     <= ST_ISSUE;
                        cmp_start_q <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    timer_q <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    timer_q <= timer_q + TMR_W'(1);
                    if (cmp_score_ready) begin
                        score_q       <= cmp_score;
                        tally_valid_q <= 1'b1;
                        state_q       <= ST_EMIT;
                    end else if (timer_q == TMR_LAST) begin
                        timeout_q <= 1'b1;
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                    end
                end
                ST_EMIT: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_scored_cnt (
        .clk (clk),
        .rst (rst),
        .inc (scored_inc),
        .q   (scored_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_skipped_cnt (
        .clk (clk),
        .rst (rst),
        .inc (skip_inc),
        .q   (skipped_count)
    );

    assign song_rd_en  = rd_en_q;
    assign ref_rd_en   = rd_en_q;
    assign cmp_start   = cmp_start_q;
    assign cmp_sung    = sung_q;
    assign cmp_ref     = ref_q;
    assign tally_valid = tally_valid_q;
    assign tally_score = score_q;
    assign timeout_err = timeout_q;
    assign busy        = busy_q;

endmodule : score_sequencer
